soc_system_phi_lock_monitor: RTL and testbench

Upstream neighbour of the `phi_locked` input PIO. It synchronizes and debounces the PLL `locked` signal and sequences single dynamic-phase-shift steps against the PLL `phasestep`/`phasedone` handshake. It also tracks the current phase position and lock-loss history. All of this is packed into one registered 32-bit status word that drives the PIO's `in_port`.

---
 rtl/soc_system_phi_lock_monitor_pkg.sv | 35 +++
 rtl/soc_system_phi_lock_monitor_if.sv | 22 ++
 rtl/soc_system_phi_lock_monitor_sync.sv | 22 ++
 rtl/soc_system_phi_lock_monitor.sv | 214 +++++++++++++++++++++
 tb/tb_soc_system_phi_lock_monitor.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/soc_system_phi_lock_monitor_pkg.sv
// Shared types and constants for the PLL phase-step / lock monitor.
// Status word layout, step FSM states and assert length.
package phi_lock_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ASSERT,
    S_WAIT_LOW,
    S_WAIT_HIGH
  } step_state_t;

  localparam int ST_LOCK     = 0;
  localparam int ST_BUSY     = 1;
  localparam int ST_LOST     = 2;
  localparam int ST_ERR      = 3;
  localparam int ST_POS_LSB  = 4;
  localparam int ST_POS_MSB  = 15;
  localparam int ST_LOSS_LSB = 16;
  localparam int ST_LOSS_MSB = 23;
  localparam int ST_STEP_LSB = 24;
  localparam int ST_STEP_MSB = 31;

  localparam int STEP_ASSERT_LEN = 2;

  typedef struct packed {
    logic [ST_STEP_MSB:ST_STEP_LSB] step_cnt;
    logic [ST_LOSS_MSB:ST_LOSS_LSB] loss_cnt;
    logic [ST_POS_MSB:ST_POS_LSB]   phase_pos;
    logic                           step_err;
    logic                           lock_lost;
    logic                           busy;
    logic                           lock_stable;
  } status_t;

endpackage

// File: rtl/soc_system_phi_lock_monitor_if.sv
// PLL dynamic-phase-shift handshake bundle.
// master = monitor side, slave = PLL side.
interface soc_system_phi_lock_monitor_if;
  logic pll_locked;
  logic phasedone;
  logic phasestep;
  logic phaseupdn;

  modport master (
    input  pll_locked,
    input  phasedone,
    output phasestep,
    output phaseupdn
  );

  modport slave (
    output pll_locked,
    output phasedone,
    input  phasestep,
    input  phaseupdn
  );
endinterface

// File: rtl/soc_system_phi_lock_monitor_sync.sv
// Multi-flop synchronizer for one asynchronous input bit.
// Depth is SYNC_STAGES; all flops reset to 0.
module phi_lock_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] ff;

  // shift the input through the synchronizer chain
  always_ff @(posedge clk or posedge reset) begin
    if (reset) ff <= '0;
    else       ff <= (ff << 1) | SYNC_STAGES'(d);
  end

  assign q = ff[SYNC_STAGES-1];

endmodule

// File: rtl/soc_system_phi_lock_monitor.sv
// PLL lock qualifier, phase-step sequencer and 32-bit status word.
// Optional step timeout: define PHI_LOCK_STEP_TIMEOUT_EN.
module soc_system_phi_lock_monitor
  import phi_lock_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int STABLE_CYCLES  = 1024,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                                clk,
  input  logic                                reset,
  soc_system_phi_lock_monitor_if.master       pll,
  input  logic                                step_toggle,
  input  logic                                step_dir,
  input  logic                                clr_toggle,
  output logic [31:0]                         status
);

  localparam int LW = $clog2(STABLE_CYCLES + 1);

  logic lock_s, done_s, step_s, clr_s;
  logic step_q, clr_q;
  logic step_edge, clr_edge;

  logic [LW-1:0] lock_cnt;
  logic          lock_stable;
  logic          lock_fall;
  logic          lock_lost;
  logic [7:0]    loss_cnt;

  step_state_t state;
  logic        ps_q, updn_q;
  logic        pending, pend_dir;
  logic [1:0]  acnt;
  logic [11:0] phase_pos;
  logic [7:0]  step_cnt;
  logic        step_err;

  logic accept, next_dir, start;
  logic abort, done_step, to_hit, retarget;

  status_t st_q;

  phi_lock_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_lock (
    .clk(clk), .reset(reset), .d(pll.pll_locked), .q(lock_s)
  );
  phi_lock_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_done (
    .clk(clk), .reset(reset), .d(pll.phasedone), .q(done_s)
  );
  phi_lock_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_step (
    .clk(clk), .reset(reset), .d(step_toggle), .q(step_s)
  );
  phi_lock_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_clr (
    .clk(clk), .reset(reset), .d(clr_toggle), .q(clr_s)
  );

  // registered copies of the toggle lines for edge detection
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      step_q <= 1'b0;
      clr_q  <= 1'b0;
    end else begin
      step_q <= step_s;
      clr_q  <= clr_s;
    end
  end

  assign step_edge = step_s ^ step_q;
  assign clr_edge  = clr_s ^ clr_q;

  // lock qualifier: count consecutive high cycles, any low resets
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lock_cnt    <= '0;
      lock_stable <= 1'b0;
    end else if (!lock_s) begin
      lock_cnt    <= '0;
      lock_stable <= 1'b0;
    end else if (lock_cnt == LW'(STABLE_CYCLES - 1)) begin
      lock_stable <= 1'b1;
    end else begin
      lock_cnt <= lock_cnt + 1'b1;
    end
  end

  // stable lock is about to drop this cycle
  assign lock_fall = lock_stable & ~lock_s;

  // lock-loss history; a loss in the same cycle as a clear wins
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lock_lost <= 1'b0;
      loss_cnt  <= '0;
    end else if (lock_fall) begin
      lock_lost <= 1'b1;
      if (loss_cnt != 8'hFF) loss_cnt <= loss_cnt + 1'b1;
    end else if (clr_edge) begin
      lock_lost <= 1'b0;
      loss_cnt  <= '0;
    end
  end

  assign accept    = step_edge & ~pending;
  assign next_dir  = pending ? pend_dir : step_dir;
  assign start     = (state == S_IDLE) & pending
                   & lock_stable & lock_s;
  assign abort     = lock_fall & (state != S_IDLE);
  assign done_step = (state == S_WAIT_HIGH) & done_s;

`ifdef PHI_LOCK_STEP_TIMEOUT_EN
  logic [12:0] tcnt;
  logic        in_wait, wait_exit;

  assign in_wait   = (state == S_WAIT_LOW) |
                     (state == S_WAIT_HIGH);
  assign wait_exit = ((state == S_WAIT_LOW) & ~done_s) |
                     done_step;
  assign to_hit    = in_wait & ~wait_exit &
                     (tcnt == 13'(TIMEOUT_CYCLES - 1));

  // per-wait-state cycle counter, restarts on every state change
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                      tcnt <= '0;
    else if (in_wait && !wait_exit) tcnt <= tcnt + 1'b1;
    else                            tcnt <= '0;
  end
`else
  assign to_hit = 1'b0;
`endif

  // direction is loaded one cycle ahead of phasestep and only
  // while idle or on the cycle the FSM returns to idle
  assign retarget = ((state == S_IDLE) | abort | to_hit | done_step)
                  & (pending | step_edge);

  // step sequencer with pending-request flag and phase tracking
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      ps_q      <= 1'b0;
      updn_q    <= 1'b0;
      pending   <= 1'b0;
      pend_dir  <= 1'b0;
      acnt      <= '0;
      phase_pos <= '0;
      step_cnt  <= '0;
      step_err  <= 1'b0;
    end else begin
      if (accept) begin
        pending  <= 1'b1;
        pend_dir <= step_dir;
      end
      if (clr_edge) step_err <= 1'b0;
      if (retarget) updn_q <= next_dir;
      if (abort || to_hit) begin
        state    <= S_IDLE;
        ps_q     <= 1'b0;
        step_err <= 1'b1;
      end else begin
        unique case (state)
          S_IDLE: begin
            if (start) begin
              state   <= S_ASSERT;
              ps_q    <= 1'b1;
              acnt    <= '0;
              pending <= 1'b0;
            end
          end
          S_ASSERT: begin
            if (acnt == 2'(STEP_ASSERT_LEN - 1)) begin
              state <= S_WAIT_LOW;
              ps_q  <= 1'b0;
            end else begin
              acnt <= acnt + 1'b1;
            end
          end
          S_WAIT_LOW: begin
            if (!done_s) state <= S_WAIT_HIGH;
          end
          S_WAIT_HIGH: begin
            if (done_s) begin
              state     <= S_IDLE;
              phase_pos <= updn_q ? phase_pos + 12'd1
                                  : phase_pos - 12'd1;
              step_cnt  <= step_cnt + 8'd1;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  assign pll.phasestep = ps_q;
  assign pll.phaseupdn = updn_q;

  // registered status word for the PIO
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st_q <= '0;
    end else begin
      st_q.lock_stable <= lock_stable;
      st_q.busy        <= (state != S_IDLE) | pending;
      st_q.lock_lost   <= lock_lost;
      st_q.step_err    <= step_err;
      st_q.phase_pos   <= phase_pos;
      st_q.loss_cnt    <= loss_cnt;
      st_q.step_cnt    <= step_cnt;
    end
  end

  assign status = st_q;

endmodule

// File: tb/tb_soc_system_phi_lock_monitor.sv
// Directed bench for soc_system_phi_lock_monitor.
// Build with PHI_LOCK_STEP_TIMEOUT_EN to cover the step timeout.
module tb_soc_system_phi_lock_monitor;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        step_toggle = 1'b0;
  logic        step_dir = 1'b0;
  logic        clr_toggle = 1'b0;
  logic [31:0] status;

  int n_chk = 0;
  int n_err = 0;
  int run_len = 0;
  int last_run = 0;
  bit model_en = 1'b0;
  bit prev_ps = 1'b0;

  always #5 clk = ~clk;

  soc_system_phi_lock_monitor_if pll_if();

  soc_system_phi_lock_monitor dut (
    .clk(clk),
    .reset(reset),
    .pll(pll_if),
    .step_toggle(step_toggle),
    .step_dir(step_dir),
    .clr_toggle(clr_toggle),
    .status(status)
  );

  task automatic chk(input string tag,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_ps(input bit v);
    int k = 0;
    while (pll_if.phasestep !== v && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (pll_if.phasestep !== v) chk("ps_wait", 32'd0, 32'd1);
  endtask

  task automatic wait_idle();
    int k = 0;
    while (status[1] !== 1'b0 && k < 400) begin
      @(negedge clk);
      k++;
    end
    if (status[1] !== 1'b0) chk("idle_wait", 32'd0, 32'd1);
  endtask

  task automatic do_step(input bit dir,
                         output int lat,
                         output bit dir_pre);
    bit seen = 1'b0;
    lat = 0;
    dir_pre = 1'b0;
    step_dir = dir;
    step_toggle = ~step_toggle;
    while (!seen && lat < 50) begin
      dir_pre = pll_if.phaseupdn;
      @(negedge clk);
      lat++;
      if (pll_if.phasestep) seen = 1'b1;
    end
    if (!seen) chk("step_start", 32'd0, 32'd1);
    wait_idle();
  endtask

  // PLL model: phasedone low 3 cycles after phasestep rises, for 4
  initial begin : pll_model
    forever begin
      @(negedge clk);
      if (model_en && pll_if.phasestep && !prev_ps) begin
        repeat (3) @(negedge clk);
        pll_if.phasedone = 1'b0;
        repeat (4) @(negedge clk);
        pll_if.phasedone = 1'b1;
      end
      prev_ps = pll_if.phasestep;
    end
  end

  // length of the most recent phasestep pulse
  initial begin : pulse_len
    forever begin
      @(negedge clk);
      if (pll_if.phasestep) run_len++;
      else if (run_len != 0) begin
        last_run = run_len;
        run_len = 0;
      end
    end
  end

  initial begin : main
    int lat;
    int nz;
    int n;
    bit dpre;
    pll_if.pll_locked = 1'b0;
    pll_if.phasedone = 1'b1;

    cycles(3);
    chk("rst_status", status, 32'h0);
    chk("rst_phasestep", {31'd0, pll_if.phasestep}, 32'd0);
    chk("rst_phaseupdn", {31'd0, pll_if.phaseupdn}, 32'd0);
    reset = 1'b0;
    cycles(5);

    pll_if.pll_locked = 1'b1;
    nz = 0;
    for (int i = 0; i < 1026; i++) begin
      @(negedge clk);
      if (status != 32'h0) nz++;
    end
    chk("pre_lock_zero", nz, 0);
    @(negedge clk);
    chk("lock_1027", status, 32'h0000_0001);

    model_en = 1'b1;
    do_step(1'b1, lat, dpre);
    chk("up_latency", lat, 4);
    chk("up_dir_pre", {31'd0, dpre}, 32'd1);
    chk("up_pulse_len", last_run, 2);
    chk("up_status", status, 32'h0100_0011);

    do_step(1'b0, lat, dpre);
    chk("dn_dir_pre", {31'd0, dpre}, 32'd0);
    chk("dn_phaseupdn", {31'd0, pll_if.phaseupdn}, 32'd0);
    chk("dn_status", status, 32'h0200_0001);

    step_dir = 1'b1;
    step_toggle = ~step_toggle;
    wait_ps(1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      step_toggle = ~step_toggle;
    end
    cycles(3);
    wait_idle();
    cycles(30);
    chk("pending_status", status, 32'h0400_0021);

    model_en = 1'b0;
    step_toggle = ~step_toggle;
    wait_ps(1'b1);
    wait_ps(1'b0);
    cycles(2);
    pll_if.pll_locked = 1'b0;
    cycles(8);
    chk("loss_status", status, 32'h0401_002C);
    chk("loss_phasestep", {31'd0, pll_if.phasestep}, 32'd0);

    clr_toggle = ~clr_toggle;
    cycles(8);
    chk("clr_status", status, 32'h0400_0020);

    pll_if.pll_locked = 1'b1;
    cycles(1030);
    chk("relock_status", status, 32'h0400_0021);

    model_en = 1'b1;
    for (int i = 0; i < 2045; i++) do_step(1'b1, lat, dpre);
    chk("pos_2047", {20'd0, status[15:4]}, 32'h0000_07FF);
    do_step(1'b1, lat, dpre);
    chk("wrap_up", status, 32'h0200_8001);
    do_step(1'b0, lat, dpre);
    chk("wrap_down", status, 32'h0300_7FF1);

    model_en = 1'b0;
    step_toggle = ~step_toggle;
    wait_ps(1'b1);
    reset = 1'b1;
    step_toggle = 1'b0;
    clr_toggle = 1'b0;
    #1;
    chk("arst_phasestep", {31'd0, pll_if.phasestep}, 32'd0);
    chk("arst_status", status, 32'h0);
    cycles(3);
    pll_if.phasedone = 1'b1;
    reset = 1'b0;
    cycles(1030);
    chk("relock2", status, 32'h0000_0001);

    step_dir = 1'b1;
    step_toggle = ~step_toggle;
    wait_ps(1'b1);
    wait_ps(1'b0);
`ifdef PHI_LOCK_STEP_TIMEOUT_EN
    n = 0;
    while (status[3] !== 1'b1 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk("timeout_cycles", n, 4097);
    chk("timeout_status", status, 32'h0000_0009);
`else
    n = 0;
    cycles(10000);
    chk("no_timeout", status, 32'h0000_0003);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
